// File: rtl/lcd_reader.sv
// HD44780 read sequencer: strobes EN with programmable setup/high/hold timing,
// captures the bus on the last EN-high cycle and optionally polls the busy flag.
module lcd_reader #(
   parameter int unsigned SETUP_CYC = 3,
   parameter int unsigned EN_HI_CYC = 25,
   parameter int unsigned HOLD_CYC  = 3,
   parameter int unsigned EN_LO_CYC = 30,
   parameter int unsigned MAX_POLLS = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rd_start,
   input  logic       rd_rs,
   input  logic       rd_poll,
   input  logic [7:0] LCD_DATA_IN,
   output logic       LCD_RW,
   output logic       LCD_RS,
   output logic       LCD_EN,
   output logic       busy,
   output logic       rd_done,
   output logic [7:0] rd_data,
   output logic       rd_timeout
);

   localparam int unsigned T_A   = (SETUP_CYC > EN_HI_CYC) ? SETUP_CYC : EN_HI_CYC;
   localparam int unsigned T_B   = (HOLD_CYC > EN_LO_CYC) ? HOLD_CYC : EN_LO_CYC;
   localparam int unsigned T_MAX = (T_A > T_B) ? T_A : T_B;
   localparam int unsigned CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] EN_LAST    = CW'(EN_HI_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] RECOV_LAST = CW'(EN_LO_CYC - 1);
   localparam logic [7:0]    POLL_MAX   = 8'(MAX_POLLS);

   typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, RECOV, DONE} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic          last;
   logic          rs_q, poll_q, rs_n, strobe_n;
   logic [7:0]    cap;
   logic [7:0]    poll_cnt;

   always_comb begin
      state_n = state;
      last    = 1'b0;
      case (state)
         IDLE:  if (rd_start) state_n = SETUP;
         SETUP: begin
            last = (cnt == SETUP_LAST);
            if (last) state_n = EN_HI;
         end
         EN_HI: begin
            last = (cnt == EN_LAST);
            if (last) state_n = HOLD;
         end
         HOLD: begin
            last = (cnt == HOLD_LAST);
            if (last)
               state_n = (poll_q && !rs_q && cap[7] && (poll_cnt < POLL_MAX)) ? RECOV : DONE;
         end
         RECOV: begin
            last = (cnt == RECOV_LAST);
            if (last) state_n = SETUP;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // RS must be valid in the first SETUP cycle, before rs_q has been latched
   always_comb begin
      rs_n     = (state == IDLE) ? rd_rs : rs_q;
      strobe_n = (state_n == SETUP) || (state_n == EN_HI) || (state_n == HOLD) || (state_n == RECOV);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)
            cnt <= '0;
         else if (state != IDLE)
            cnt <= cnt + CW'(1);
      end
   end

   // Panel and handshake outputs are registered from the next state so EN is a clean flop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs_q       <= 1'b0;
         poll_q     <= 1'b0;
         poll_cnt   <= '0;
         cap        <= '0;
         LCD_EN     <= 1'b0;
         LCD_RW     <= 1'b0;
         LCD_RS     <= 1'b0;
         busy       <= 1'b0;
         rd_done    <= 1'b0;
         rd_data    <= '0;
         rd_timeout <= 1'b0;
      end else begin
         if (state == IDLE && rd_start) begin
            rs_q     <= rd_rs;
            poll_q   <= rd_poll;
            poll_cnt <= '0;
         end
         if (state == EN_HI && last)
            cap <= LCD_DATA_IN;
         if (state == RECOV && last && poll_cnt != '1)
            poll_cnt <= poll_cnt + 8'd1;
         LCD_EN  <= (state_n == EN_HI);
         LCD_RW  <= strobe_n;
         LCD_RS  <= strobe_n & rs_n;
         busy    <= (state_n != IDLE);
         rd_done <= (state_n == DONE);
         if (state_n == DONE) begin
            rd_data    <= cap;
            rd_timeout <= poll_q & ~rs_q & cap[7];
         end
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Scoreboard bench for lcd_reader: a panel model feeds the bus per EN strobe and
// a monitor checks every rd_done against results predicted from the read rules.
module tb_lcd_reader;

   localparam int SETUP_C = 3;
   localparam int ENH_C   = 25;
   localparam int HOLD_C  = 3;
   localparam int RECOV_C = 30;
   localparam int MAXP    = 4;
   localparam int ONE_RD  = 1 + SETUP_C + ENH_C + HOLD_C;
   localparam int REPOLL  = RECOV_C + SETUP_C + ENH_C + HOLD_C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rd_start = 1'b0;
   logic       rd_rs = 1'b0;
   logic       rd_poll = 1'b0;
   logic [7:0] LCD_DATA_IN = '0;
   logic       LCD_RW, LCD_RS, LCD_EN, busy, rd_done, rd_timeout;
   logic [7:0] rd_data;

   lcd_reader #(.SETUP_CYC(SETUP_C), .EN_HI_CYC(ENH_C), .HOLD_CYC(HOLD_C),
                .EN_LO_CYC(RECOV_C), .MAX_POLLS(MAXP)) dut (
      .clk(clk), .rst(rst), .rd_start(rd_start), .rd_rs(rd_rs), .rd_poll(rd_poll),
      .LCD_DATA_IN(LCD_DATA_IN), .LCD_RW(LCD_RW), .LCD_RS(LCD_RS), .LCD_EN(LCD_EN),
      .busy(busy), .rd_done(rd_done), .rd_data(rd_data), .rd_timeout(rd_timeout));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       tmo;
      int         done_edge;
      int         pulses;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] bus_vals[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   logic       cur_rs = 1'b0;
   int         chg_idx = -1;
   logic [7:0] chg_val = '0;
   bit         fall_en = 1'b0;
   logic [7:0] fall_val = '0;

   bit         en_prev = 1'b0;
   int         hi_cnt = 0;
   int         pulse_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Panel model plus output monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         en_prev   = 1'b0;
         pulse_cnt = 0;
         hi_cnt    = 0;
      end else begin
         if (LCD_EN && !en_prev) begin
            hi_cnt = 0;
            pulse_cnt++;
            if (bus_vals.size() > 0) LCD_DATA_IN = bus_vals.pop_front();
         end else if (LCD_EN) begin
            hi_cnt++;
         end
         if (LCD_EN) begin
            chk("rw_during_en", int'(LCD_RW), 1);
            chk("rs_during_en", int'(LCD_RS), int'(cur_rs));
            if (hi_cnt == chg_idx) LCD_DATA_IN = chg_val;
         end
         if (!LCD_EN && en_prev) begin
            chk("en_width", hi_cnt + 1, ENH_C);
            if (fall_en) LCD_DATA_IN = fall_val;
         end
         if (rd_done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("rd_data", int'(rd_data), int'(e.data));
               chk("rd_timeout", int'(rd_timeout), int'(e.tmo));
               chk("done_edge", cyc + 1, e.done_edge);
               chk("en_pulses", pulse_cnt, e.pulses);
               chk("busy_at_done", int'(busy), 1);
            end
            pulse_cnt = 0;
         end
         en_prev = LCD_EN;
      end
   end

   // Reference: one read, or with poll on the busy register keep re-reading
   // while bit 7 is set and fewer than MAX_POLLS re-reads have been made.
   task automatic start_read(input logic rs, input logic poll, input logic [7:0] v [8]);
      exp_t       e;
      int         n;
      logic [7:0] res;
      n   = 1;
      res = v[0];
      if (poll && !rs) begin
         while (res[7] && (n - 1) < MAXP) begin
            res = v[n];
            n++;
         end
      end
      for (int i = 0; i < n; i++) bus_vals.push_back(v[i]);
      @(negedge clk);
      e.data      = res;
      e.tmo       = poll & ~rs & res[7];
      e.pulses    = n;
      e.done_edge = (cyc + 1) + ONE_RD + (n - 1) * REPOLL;
      sb.push_back(e);
      cur_rs   = rs;
      rd_rs    = rs;
      rd_poll  = poll;
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      rd_rs    = 1'($urandom);
      rd_poll  = 1'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", int'(sb.size()), 0);
         sb.delete();
         bus_vals.delete();
      end
   endtask

   task automatic wait_en();
      for (int i = 0; i < 100 && !LCD_EN; i++) @(negedge clk);
      chk("en_rise", int'(LCD_EN), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_en"}, int'(LCD_EN), 0);
      chk({tag, "_rw"}, int'(LCD_RW), 0);
      chk({tag, "_rs"}, int'(LCD_RS), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(rd_done), 0);
      chk({tag, "_data"}, int'(rd_data), 0);
      chk({tag, "_tmo"}, int'(rd_timeout), 0);
   endtask

   initial begin
      logic [7:0] v [8];
      for (int i = 0; i < 8; i++) v[i] = '0;

      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      rst = 1'b1;
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_rw", int'(LCD_RW), 0);

      // single data read
      v[0] = 8'h41;
      start_read(1'b1, 1'b0, v);
      wait_done();

      // rs=1 with poll set: still exactly one read
      v[0] = 8'h85;
      start_read(1'b1, 1'b1, v);
      wait_done();

      // busy-flag poll clearing on the 4th strobe
      v[0] = 8'h85; v[1] = 8'h85; v[2] = 8'h85; v[3] = 8'h05;
      start_read(1'b0, 1'b1, v);
      wait_done();

      // poll timeout with the flag stuck
      for (int i = 0; i < 8; i++) v[i] = 8'h80;
      start_read(1'b0, 1'b1, v);
      wait_done();

      // bus changes in the last EN-high cycle, then again on the EN-fall cycle:
      // the value present during the last high cycle is what gets captured
      v[0]     = 8'h11;
      chg_idx  = ENH_C - 1;
      chg_val  = 8'h22;
      fall_en  = 1'b1;
      fall_val = 8'h99;
      start_read(1'b1, 1'b0, v);
      sb[sb.size() - 1].data = 8'h22;
      wait_done();
      chg_idx = -1;
      fall_en = 1'b0;

      // second request during EN_HI is ignored
      v[0] = 8'h5a;
      start_read(1'b1, 1'b0, v);
      wait_en();
      repeat (10) @(negedge clk);
      rd_start = 1'b1;
      @(negedge clk);
      rd_start = 1'b0;
      wait_done();
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      repeat (40) @(negedge clk);

      // reset in the middle of the strobe
      v[0] = 8'h77;
      start_read(1'b1, 1'b0, v);
      wait_en();
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      sb.delete();
      bus_vals.delete();
      #1 chk_reset_outs("abort");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      v[0] = 8'h3c;
      start_read(1'b1, 1'b0, v);
      wait_done();

      // randomized reads, busy flag biased high to exercise polling
      for (int t = 0; t < 40; t++) begin
         logic rs, poll;
         rs   = 1'($urandom_range(0, 1));
         poll = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++)
            v[i] = {($urandom_range(0, 3) != 0), 7'($urandom)};
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_read(rs, poll, v);
         wait_done();
      end

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
